beta_serial: RTL and testbench

//  Iterative, parametrised beta (S-box column) layer for one cipher half (SIDE_SIZE bits).

---
 rtl/beta_serial.sv | 138 +++++++++++++
 tb/tb_beta_serial.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/beta_serial.sv
// beta_serial: iterative SWAN beta layer, LANES 4-bit columns per clock, valid/ready on both sides.
// Define BETA_SERIAL_INV_EN to build the inverse S-box lanes selected by the captured mode.
module sbox (
    input  logic [3:0] a_i,
    output logic [3:0] b_o
);
    localparam logic [63:0] TABLE = 64'h2174_8FE3_DA09_B65C;
    assign b_o = TABLE[{a_i, 2'b00} +: 4];
endmodule

module sbox_inv (
    input  logic [3:0] a_i,
    output logic [3:0] b_o
);
    localparam logic [63:0] TABLE = 64'hA970_364B_D21C_8FE5;
    assign b_o = TABLE[{a_i, 2'b00} +: 4];
endmodule

module beta_serial #(
    parameter int BLOCK_SIZE  = 64,
    parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
    parameter int COLUMN_SIZE = SIDE_SIZE / 4,
    parameter int SBOX_SIZE   = 4,
    parameter int LANES       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [0:SIDE_SIZE-1] x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:SIDE_SIZE-1] y,
    output logic                 busy
);
    localparam int LN = (LANES < 1) ? 1 : LANES;
    localparam int N  = (COLUMN_SIZE / LN < 1) ? 1 : COLUMN_SIZE / LN;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int G  = 2 ** CW;
    localparam int C  = COLUMN_SIZE;

    if (LANES == 0 || COLUMN_SIZE % LN != 0 || SBOX_SIZE != 4 ||
        !(BLOCK_SIZE == 64 || BLOCK_SIZE == 128 || BLOCK_SIZE == 256)) begin : g_bad
        $error("beta_serial: illegal BLOCK_SIZE/LANES/SBOX_SIZE combination");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [0:SIDE_SIZE-1] data_q, data_d, step;
    logic                 last;
    logic [3:0]           cols [C];
    logic [3:0]           grp  [G][LN];
    logic [3:0]           nib  [LN];
    logic [3:0]           fwd  [LN];
    logic [3:0]           res  [LN];

    // Column j gathers bits j, j+C, j+2C, j+3C (MSB first); only the active group is rewritten.
    for (genvar j = 0; j < C; j++) begin : g_col
        assign cols[j] = {data_q[j], data_q[j+C], data_q[j+2*C], data_q[j+3*C]};
        assign {step[j], step[j+C], step[j+2*C], step[j+3*C]} =
            (cnt_q == CW'(j / LN)) ? res[j % LN] : cols[j];
    end

    for (genvar g = 0; g < G; g++) begin : g_grp
        for (genvar l = 0; l < LN; l++) begin : g_lane
            if (g < N) begin : g_on
                assign grp[g][l] = cols[g*LN + l];
            end else begin : g_off
                assign grp[g][l] = '0;
            end
        end
    end

`ifdef BETA_SERIAL_INV_EN
    logic       mode_q;
    logic [3:0] inv [LN];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= 1'b0;
        else if (state_q == IDLE && in_valid) mode_q <= mode;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    for (genvar l = 0; l < LN; l++) begin : g_sbox
        assign nib[l] = grp[cnt_q][l];
        sbox u_fwd (.a_i(nib[l]), .b_o(fwd[l]));
`ifdef BETA_SERIAL_INV_EN
        sbox_inv u_inv (.a_i(nib[l]), .b_o(inv[l]));
        assign res[l] = mode_q ? inv[l] : fwd[l];
`else
        assign res[l] = fwd[l];
`endif
    end

    assign last = cnt_q == CW'(N - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = BUSY;
                cnt_d   = '0;
                data_d  = x;
            end
            BUSY: begin
                data_d  = step;
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                state_d = last ? DONE : BUSY;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q == BUSY;
    assign out_valid = state_q == DONE;
    assign y         = data_q;
endmodule

// File: tb/tb_beta_serial.sv
// tb_beta_serial: random and directed checks of beta_serial against a whole-block beta model.
module tb_beta_serial;
    localparam int BS = 64;
    localparam int LN = 2;
    localparam int SW = BS / 2;
    localparam int C  = SW / 4;
    localparam int N  = C / LN;
`ifdef BETA_SERIAL_INV_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid, busy;
    logic [0:SW-1] x = '0, y;
    int            total = 0, bad = 0;
    int            SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    int            SI [16] = '{5, 14, 15, 8, 12, 1, 2, 13, 11, 4, 6, 3, 0, 7, 9, 10};

    always #5 clk = ~clk;

    beta_serial #(.BLOCK_SIZE(BS), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    function automatic logic [0:SW-1] beta(input logic [0:SW-1] v, input logic m);
        logic [0:SW-1] r;
        logic [3:0]    n, s;
        r = v;
        for (int j = 0; j < C; j++) begin
            n = {v[j], v[j+C], v[j+2*C], v[j+3*C]};
            s = (INV && m) ? 4'(SI[n]) : 4'(SB[n]);
            {r[j], r[j+C], r[j+2*C], r[j+3*C]} = s;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rand_word(output logic [0:SW-1] v);
        for (int i = 0; i < SW; i++) v[i] = 1'($urandom_range(0, 1));
    endtask

    // Leaves the bench at the first falling edge after the accept edge.
    task automatic send(input logic [0:SW-1] v, input logic m);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("in_ready_timeout", SW'(in_ready), SW'(1));
        in_valid = 1'b1;
        x        = v;
        mode     = m;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("done_timeout", SW'(out_valid), SW'(1));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_release", SW'({in_ready, out_valid, busy}), SW'(3'b100));
    endtask

    task automatic run(input logic [0:SW-1] v, input logic m, input string tag,
                       output logic [0:SW-1] got);
        int lat;
        send(v, m);
        wait_done(lat);
        chk({tag, "_latency"}, SW'(lat), SW'(N));
        chk({tag, "_y"}, y, beta(v, m));
        got = y;
        release_out();
    endtask

    initial begin
        logic [0:SW-1] v, v2, y1, y2, hold, exp;
        logic          m;
        int            lat;
        repeat (2) @(negedge clk);
        chk("reset_flags", SW'({in_ready, out_valid, busy}), SW'(3'b100));
        chk("reset_y", y, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_flags", SW'({in_ready, out_valid, busy}), SW'(3'b100));

        // zero input: every column becomes sbox(0)
        send('0, 1'b0);
        chk("busy_after_accept", SW'({in_ready, busy}), SW'(2'b01));
        wait_done(lat);
        chk("zero_latency", SW'(lat), SW'(N));
        exp = '0;
        for (int j = 0; j < C; j++) {exp[j], exp[j+C], exp[j+2*C], exp[j+3*C]} = 4'(SB[0]);
        chk("zero_y", y, exp);
        release_out();

        // reset mid-BUSY at cnt = 2
        rand_word(v);
        send(v, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_flags", SW'({in_ready, out_valid, busy}), SW'(3'b100));
        chk("midreset_y", y, '0);
        @(negedge clk);
        rst = 1'b0;
        rand_word(v);
        run(v, 1'b0, "after_reset", y1);

        // backpressure with an in_valid pulse while DONE
        rand_word(v);
        send(v, 1'b1);
        wait_done(lat);
        hold = y;
        chk("bp_y", hold, beta(v, 1'b1));
        for (int i = 0; i < 10; i++) begin
            rand_word(v2);
            in_valid = (i == 4);
            x        = v2;
            @(negedge clk);
            in_valid = 1'b0;
            chk("bp_hold_y", y, hold);
            chk("bp_hold_flags", SW'({in_ready, out_valid, busy}), SW'(3'b010));
        end
        release_out();
        chk("bp_pulse_dropped", SW'(busy), SW'(0));

        // round trip through forward then inverse mode
        v = '0;
        for (int i = 0; i < SW; i++) v[i] = 1'(i / 4 % 2);
        if (SW == 32) v = 32'h0123_4567;
        run(v, 1'b0, "rt_fwd", y1);
        run(y1, 1'b1, "rt_inv", y2);
        exp = INV ? v : beta(y1, 1'b0);
        chk("rt_result", y2, exp);

        // inputs churn while BUSY; only the captured values matter
        rand_word(v);
        send(v, 1'b0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            rand_word(x);
            mode = ~mode;
            @(negedge clk);
            lat++;
        end
        chk("churn_latency", SW'(lat), SW'(N));
        chk("churn_y", y, beta(v, 1'b0));
        release_out();

        // random words with random downstream stalls
        for (int t = 0; t < 300; t++) begin
            rand_word(v);
            m = 1'($urandom_range(0, 1));
            send(v, m);
            wait_done(lat);
            chk("rand_latency", SW'(lat), SW'(N));
            hold = y;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk("rand_y", y, beta(v, m));
            chk("rand_stable", y, hold);
            release_out();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
